// File: rtl/stopwatch_pkg.sv
// Shared display constants and types for the stopwatch digit bus and its
// seven-segment consumers.
package stopwatch_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;

  // Active-low segment patterns, bit order g f e d c b a
  localparam logic [SEG_W-1:0] SEG_0    = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1    = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2    = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3    = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4    = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5    = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6    = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7    = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8    = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9    = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH = 7'b0111111;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;
  localparam logic [SEG_W:0]        SSEG_OFF  = 8'hFF;

  typedef logic [1:0] slot_t;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][BCD_W-1:0] dig;
    logic [NUM_DIGITS-1:0]            dp;
  } digit_frame_t;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes show a dash.
module bcd_to_sseg
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_sseg_mux.sv
// Four-digit common-anode display scanner with frame-consistent digit capture
// and per-slot anti-ghosting guard. SSEG_LZ_BLANK_EN enables leading-zero blanking.
module stopwatch_sseg_mux
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD_CYC   = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BCD_W-1:0]      d3,
  input  logic [BCD_W-1:0]      d2,
  input  logic [BCD_W-1:0]      d1,
  input  logic [BCD_W-1:0]      d0,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W:0]        sseg,
  output logic                  frame_tick
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  slot_t                 slot_q, slot_d;
  digit_frame_t          shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W:0]        sseg_q, sseg_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  load_c;
  logic                  in_guard_c;
  logic [NUM_DIGITS-1:0] lz_blank_c;
  logic [BCD_W-1:0]      cur_bcd_c;
  logic [SEG_W-1:0]      cur_seg_c;

  bcd_to_sseg u_dec (
    .bcd   (cur_bcd_c),
    .seg_c (cur_seg_c)
  );

  // Leading-zero suppression works on the frozen shadow so a frame never tears
  always_comb begin
    lz_blank_c = '0;
`ifdef SSEG_LZ_BLANK_EN
    lz_blank_c[3] = (shadow_q.dig[3] == '0) && !shadow_q.dp[3];
    lz_blank_c[2] = (shadow_q.dig[3] == '0) && (shadow_q.dig[2] == '0) && !shadow_q.dp[2];
    lz_blank_c[1] = (shadow_q.dig[3] == '0) && (shadow_q.dig[2] == '0) &&
                    (shadow_q.dig[1] == '0) && !shadow_q.dp[1];
`endif
  end

  always_comb begin
    div_d        = div_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    an_d         = ANODE_OFF;
    sseg_d       = SSEG_OFF;
    frame_tick_d = 1'b0;

    load_c     = (div_q == '0) && (slot_q == 2'd0);
    in_guard_c = (GUARD_CYC != 0) && (div_q < DIV_W'(GUARD_CYC));
    cur_bcd_c  = shadow_q.dig[slot_q];

    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d  = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (load_c) begin
      shadow_d.dig = {d3, d2, d1, d0};
      shadow_d.dp  = dp_in;
    end
    frame_tick_d = load_c;

    // Segments lead the anode: the guard already shows the upcoming digit
    sseg_d = {~shadow_q.dp[slot_q], cur_seg_c};
    if (!(blank || in_guard_c || lz_blank_c[slot_q])) begin
      an_d = ~(4'(4'b0001 << slot_q));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      slot_q       <= 2'd0;
      shadow_q     <= '0;
      an_q         <= ANODE_OFF;
      sseg_q       <= SSEG_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: doc/stopwatch_sseg_mux.md
Name: stopwatch_sseg_mux

Overview:
Display-side consumer of the stopwatch BCD digit bus. Takes four BCD digits plus per-digit decimal points and drives a 4-digit common-anode seven-segment display by time-multiplexing.
- Frame-consistent shadow capture: all digits sampled together at frame start.
- Anti-ghosting guard interval at the start of every digit slot.
- Registered, active-low anode and segment outputs.
- Sits between the stopwatch counter and the board pins.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot; legal range 2..2^20.
GUARD_CYC, 500, cycles at the start of each slot with all anodes off; must satisfy 0 <= GUARD_CYC < REFRESH_DIV.

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
d3  input  4  BCD digit, most significant
d2  input  4  BCD digit
d1  input  4  BCD digit
d0  input  4  BCD digit, least significant
dp_in  input  4  decimal point per digit, bit i belongs to digit i, 1 = lit
blank  input  1  1 = all anodes off; counters keep running
an  output  4  anode enables, active-low, bit i = digit i
sseg  output  8  segments, active-low; bit7 = dp, bits6..0 = g f e d c b a
frame_tick  output  1  one-cycle pulse at each shadow load

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low on rst_n, sampled on the rising edge of clk.
- Reset values:
  - div = 0, slot = 0.
  - Shadow digits/dp = 0.
  - an = 4'b1111, sseg = 8'hFF, frame_tick = 0.
- Divider:
  - div counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, slot advances 0→1→2→3→0.
  - Frame = 4*REFRESH_DIV cycles.
- Shadow load:
  - In any cycle with div==0 and slot==0, including the first cycle after rst_n rises, the shadow registers capture d3..d0 and dp_in.
  - frame_tick is registered: it is 1 in the following cycle.
  - Input changes at any other time are ignored until the next load.
- Slot phases, evaluated per cycle on the current div/slot:
  - GUARD (div < GUARD_CYC): an next = 4'b1111.
  - ON (div >= GUARD_CYC): an next = one-cold at bit slot.
  - sseg next = decode(shadow[slot]), with bit7 = ~shadow_dp[slot].
  - During GUARD, sseg still shows the upcoming digit.
- Latency: an, sseg and frame_tick are registered, so they lag div/slot by exactly 1 cycle.
- blank=1 forces an next = 4'b1111 in any phase. div, slot, shadow load and frame_tick are unaffected.
- Decode, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10..15 display dash = 0111111.
- Reset mid-frame: outputs return to reset values on the next edge; scan restarts at slot 0 with a fresh shadow load.
- Boundary: GUARD_CYC=0 means no guard; the anode is active for the full slot.

Optional Feature:
SSEG_LZ_BLANK_EN
- Defined: leading-zero suppression on shadow values.
  - Digit 3 blanked if shadow d3==0.
  - Digit 2 blanked if d3==0 and d2==0.
  - Digit 1 blanked if d3==0, d2==0 and d1==0.
  - A blanked digit keeps an=1111 for its entire slot.
  - Digit 0 is never suppressed.
  - A digit's dp=1 cancels its suppression.
- Undefined: all four digits are always shown.

Decomposition:
- Package stopwatch_pkg holds:
  - SEG_0..SEG_9 and SEG_DASH 7-bit constants.
  - Slot index type (2-bit).
  - Anode-off constant 4'b1111.
- One natural sub-module: bcd_to_sseg, a combinational 4-bit → 7-bit decoder reused by other display blocks.

Test Plan:
All scenarios use REFRESH_DIV=8 and GUARD_CYC=2; frame = 32 cycles.
1. rst_n=0 for 5 cycles → an=1111, sseg=8'hFF, frame_tick=0. Release reset → frame_tick=1 on the 2nd cycle after release, then every 32 cycles.
2. d3..d0=1,2,3,4, dp_in=0 → per slot: 2 cycles an=1111, then 6 cycles of the active anode.
   - Slot 0: an=1110, sseg=8'h99.
   - Slot 3: an=0111, sseg=8'hF9.
3. Change d0 from 4 to 5 mid-frame → slot 0 keeps 8'h99 until after the next frame_tick, then shows 8'h92.
4. d1=4'hB, dp_in=4'b0010 → slot 1 sseg=8'h3F (dash with dp lit).
5. blank=1 for one full frame → an=1111 throughout, while frame_tick keeps a 32-cycle period.
6. d3..d0=0,0,0,7:
   - With SSEG_LZ_BLANK_EN: slots 1..3 an=1111 throughout; slot 0 sseg=8'hF8.
   - Without it: slots 1..3 show sseg=8'hC0.
